// File: rtl/proc_pkg.sv
// Shared processor types and default widths used by the ALU, register file
// and memory-stage controller.
package proc_pkg;

  localparam int PROC_DATA_W = 32;
  localparam int PROC_ADDR_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } memctl_state_t;

endpackage : proc_pkg

// File: rtl/mem_timeout_cnt.sv
// Counts cycles spent waiting for the external memory; flags the last
// allowed cycle so the controller can abort on the following edge.
module mem_timeout_cnt #(
  parameter int TIMEOUT = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CNT_W'(1);
    end
  end

  // High during the TIMEOUT-th waiting cycle, so the request is held exactly TIMEOUT cycles.
  assign expired = (count == CNT_W'(TIMEOUT - 1));

endmodule : mem_timeout_cnt

// File: rtl/data_mem_ctrl.sv
// Memory-stage controller: accepts one load/store, runs a req/ack handshake
// with the data RAM, stalls the pipeline meanwhile and returns load data.
module data_mem_ctrl
  import proc_pkg::*;
#(
  parameter int DATA_W  = PROC_DATA_W,
  parameter int ADDR_W  = PROC_ADDR_W,
  parameter int TIMEOUT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_RE,
  input  logic              mem_WE,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              stall,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_valid,
  output logic              err,
  output logic              ext_req,
  output logic              ext_we,
  output logic [ADDR_W-1:0] ext_addr,
  output logic [DATA_W-1:0] ext_wdata,
  input  logic              ext_ack,
  input  logic [DATA_W-1:0] ext_rdata
);

  memctl_state_t state, next_state;

  logic accept;
  logic illegal;
  logic ack_hit;
  logic abort;
  logic expired;

  // Reset wins over any request, so nothing is accepted (and no stall raised) during it.
  assign accept  = !rst && (state == IDLE) && (mem_RE ^ mem_WE);
  assign illegal = !rst && (state == IDLE) && mem_RE && mem_WE;
  assign ack_hit = (state == REQ) && ext_ack;
  assign abort   = (state == REQ) && !ext_ack && expired;

  assign ext_req = (state == REQ);
  assign stall   = accept || (state == REQ);

  mem_timeout_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clear   (accept),
    .enable  (state == REQ),
    .expired (expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // NOTE: next_state gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = REQ;
      REQ:     if (ack_hit || abort) next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ext_we      <= 1'b0;
      ext_addr    <= '0;
      ext_wdata   <= '0;
      rdata       <= '0;
      rdata_valid <= 1'b0;
      err         <= 1'b0;
    end else begin
      // err and rdata_valid are single-cycle pulses.
      rdata_valid <= 1'b0;
      err         <= 1'b0;
      if (accept) begin
        ext_we    <= mem_WE;
        ext_addr  <= addr;
        ext_wdata <= wdata;
      end
      if (illegal) begin
        err <= 1'b1;
      end
      if (ack_hit && !ext_we) begin
        rdata       <= ext_rdata;
        rdata_valid <= 1'b1;
      end
      if (abort) begin
        err   <= 1'b1;
        rdata <= '0;
      end
    end
  end

endmodule : data_mem_ctrl

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl: reset, load, store, timeout, illegal
// request and reset during an outstanding request.
module tb_data_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_RE;
  logic        mem_WE;
  logic [15:0] addr;
  logic [31:0] wdata;
  logic        stall;
  logic [31:0] rdata;
  logic        rdata_valid;
  logic        err;
  logic        ext_req;
  logic        ext_we;
  logic [15:0] ext_addr;
  logic [31:0] ext_wdata;
  logic        ext_ack;
  logic [31:0] ext_rdata;

  int tests = 0;
  int fails = 0;

  data_mem_ctrl #(
    .DATA_W  (32),
    .ADDR_W  (16),
    .TIMEOUT (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .mem_RE      (mem_RE),
    .mem_WE      (mem_WE),
    .addr        (addr),
    .wdata       (wdata),
    .stall       (stall),
    .rdata       (rdata),
    .rdata_valid (rdata_valid),
    .err         (err),
    .ext_req     (ext_req),
    .ext_we      (ext_we),
    .ext_addr    (ext_addr),
    .ext_wdata   (ext_wdata),
    .ext_ack     (ext_ack),
    .ext_rdata   (ext_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // 1. reset with random inputs
    rst       = 1'b1;
    mem_RE    = 1'($urandom);
    mem_WE    = 1'($urandom);
    addr      = 16'($urandom);
    wdata     = $urandom;
    ext_ack   = 1'($urandom);
    ext_rdata = $urandom;
    tick();
    tick();
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_ext_req", {31'd0, ext_req}, 32'd0);
    check("rst_ext_we", {31'd0, ext_we}, 32'd0);
    check("rst_ext_addr", {16'd0, ext_addr}, 32'd0);
    check("rst_ext_wdata", ext_wdata, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_rdata_valid", {31'd0, rdata_valid}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);

    // 2. load, ack in 3rd REQ cycle
    rst       = 1'b0;
    mem_RE    = 1'b1;
    mem_WE    = 1'b0;
    addr      = 16'h0010;
    wdata     = 32'hAAAA5555;
    ext_ack   = 1'b0;
    ext_rdata = 32'h0;
    #1;
    check("ld_accept_stall", {31'd0, stall}, 32'd1);
    check("ld_accept_req", {31'd0, ext_req}, 32'd0);
    tick();
    mem_RE = 1'b0;
    addr   = 16'hFFFF;
    #1;
    check("ld_req1_req", {31'd0, ext_req}, 32'd1);
    check("ld_req1_we", {31'd0, ext_we}, 32'd0);
    check("ld_req1_addr", {16'd0, ext_addr}, 32'h0010);
    check("ld_req1_stall", {31'd0, stall}, 32'd1);
    tick();
    check("ld_req2_req", {31'd0, ext_req}, 32'd1);
    check("ld_req2_stall", {31'd0, stall}, 32'd1);
    tick();
    ext_ack   = 1'b1;
    ext_rdata = 32'hDEADBEEF;
    #1;
    check("ld_req3_req", {31'd0, ext_req}, 32'd1);
    check("ld_req3_stall", {31'd0, stall}, 32'd1);
    check("ld_req3_valid", {31'd0, rdata_valid}, 32'd0);
    tick();
    ext_ack   = 1'b0;
    ext_rdata = 32'h0BAD0BAD;
    #1;
    check("ld_resp_stall", {31'd0, stall}, 32'd0);
    check("ld_resp_req", {31'd0, ext_req}, 32'd0);
    check("ld_resp_rdata", rdata, 32'hDEADBEEF);
    check("ld_resp_valid", {31'd0, rdata_valid}, 32'd1);
    check("ld_resp_err", {31'd0, err}, 32'd0);
    tick();
    check("ld_idle_valid", {31'd0, rdata_valid}, 32'd0);
    check("ld_idle_rdata_hold", rdata, 32'hDEADBEEF);
    check("ld_idle_stall", {31'd0, stall}, 32'd0);

    // 3. store, ack in 1st REQ cycle
    mem_WE = 1'b1;
    addr   = 16'h0020;
    wdata  = 32'h12345678;
    #1;
    check("st_accept_stall", {31'd0, stall}, 32'd1);
    tick();
    mem_WE    = 1'b0;
    wdata     = 32'h0;
    ext_ack   = 1'b1;
    ext_rdata = 32'hCAFEF00D;
    #1;
    check("st_req_req", {31'd0, ext_req}, 32'd1);
    check("st_req_we", {31'd0, ext_we}, 32'd1);
    check("st_req_addr", {16'd0, ext_addr}, 32'h0020);
    check("st_req_wdata", ext_wdata, 32'h12345678);
    check("st_req_stall", {31'd0, stall}, 32'd1);
    tick();
    ext_ack = 1'b0;
    #1;
    check("st_resp_stall", {31'd0, stall}, 32'd0);
    check("st_resp_valid", {31'd0, rdata_valid}, 32'd0);
    check("st_resp_rdata", rdata, 32'hDEADBEEF);
    check("st_resp_err", {31'd0, err}, 32'd0);
    tick();

    // 4. load with no ack: timeout after exactly 8 REQ cycles
    mem_RE = 1'b1;
    addr   = 16'h0030;
    tick();
    mem_RE = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1;
      check($sformatf("to_req%0d_req", i + 1), {31'd0, ext_req}, 32'd1);
      check($sformatf("to_req%0d_stall", i + 1), {31'd0, stall}, 32'd1);
      tick();
    end
    check("to_resp_req", {31'd0, ext_req}, 32'd0);
    check("to_resp_err", {31'd0, err}, 32'd1);
    check("to_resp_rdata", rdata, 32'd0);
    check("to_resp_valid", {31'd0, rdata_valid}, 32'd0);
    check("to_resp_stall", {31'd0, stall}, 32'd0);
    tick();
    check("to_idle_err", {31'd0, err}, 32'd0);

    // 5. illegal RE & WE in IDLE
    mem_RE = 1'b1;
    mem_WE = 1'b1;
    addr   = 16'h0050;
    #1;
    check("ill_stall", {31'd0, stall}, 32'd0);
    check("ill_req", {31'd0, ext_req}, 32'd0);
    tick();
    mem_RE = 1'b0;
    mem_WE = 1'b0;
    #1;
    check("ill_err", {31'd0, err}, 32'd1);
    check("ill_next_req", {31'd0, ext_req}, 32'd0);
    check("ill_next_stall", {31'd0, stall}, 32'd0);
    tick();
    check("ill_err_drop", {31'd0, err}, 32'd0);
    check("ill_idle_req", {31'd0, ext_req}, 32'd0);

    // 6. reset during 2nd REQ cycle, then a stray ack
    mem_RE = 1'b1;
    addr   = 16'h0040;
    tick();
    mem_RE = 1'b0;
    tick();
    check("rr_req2_req", {31'd0, ext_req}, 32'd1);
    rst = 1'b1;
    tick();
    rst       = 1'b0;
    ext_ack   = 1'b1;
    ext_rdata = 32'h55555555;
    #1;
    check("rr_after_req", {31'd0, ext_req}, 32'd0);
    check("rr_after_stall", {31'd0, stall}, 32'd0);
    check("rr_after_addr", {16'd0, ext_addr}, 32'd0);
    tick();
    ext_ack = 1'b0;
    #1;
    check("rr_stray_valid", {31'd0, rdata_valid}, 32'd0);
    check("rr_stray_err", {31'd0, err}, 32'd0);
    check("rr_stray_rdata", rdata, 32'd0);
    check("rr_stray_req", {31'd0, ext_req}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_data_mem_ctrl
